// File: rtl/schoolbook_sched_pkg.sv
// Shared types and constants for the schoolbook multiplier scheduler.
package schoolbook_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int DEF_WIDTH = 283;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNTW  = $clog2(DEF_WIDTH + 1);

    // The step counter must be able to hold WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/schoolbook_sched_if.sv
// Requester/result bundle between the field-arithmetic clients and the scheduler.
interface schoolbook_sched_if
    import schoolbook_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*WIDTH-1:0]    res_c;
    logic [IDW-1:0]        res_id;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_c, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_c, res_id, busy
    );

endinterface

// File: rtl/schoolbook_sched_core.sv
// Bit-serial shift-and-add multiplier, one bit of b per cycle.
// SCHOOLBOOK_SCHED_EARLY_TERM_EN: finish as soon as no set bits of b remain.
module schoolbook_core
    import schoolbook_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);
    localparam int CNTW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [CNTW-1:0]    cnt_reg;
    logic               run_reg;
    logic               last_step;

`ifdef SCHOOLBOOK_SCHED_EARLY_TERM_EN
    assign last_step = (cnt_reg == CNTW'(WIDTH - 1)) || (b_sh_reg[WIDTH-1:1] == '0);
`else
    assign last_step = (cnt_reg == CNTW'(WIDTH - 1));
`endif

    // done is combinational so the scheduler leaves MUL on the final step edge.
    assign done = run_reg & last_step;
    assign c    = acc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
        end else if (start) begin
            acc_reg  <= '0;
            a_sh_reg <= {{WIDTH{1'b0}}, a};
            b_sh_reg <= b;
            cnt_reg  <= '0;
            run_reg  <= 1'b1;
        end else if (run_reg) begin
            if (b_sh_reg[0]) begin
                acc_reg <= acc_reg + a_sh_reg;
            end
            a_sh_reg <= a_sh_reg << 1;
            b_sh_reg <= b_sh_reg >> 1;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_step) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/schoolbook_sched.sv
// Round-robin scheduler sharing one schoolbook_core between NREQ requesters.
// Build option SCHOOLBOOK_SCHED_EARLY_TERM_EN (applied inside schoolbook_core).
module schoolbook_sched
    import schoolbook_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    schoolbook_sched_if.slave  bus
);
    sched_state_t state_reg, state_next;

    logic [IDW-1:0]   rr_reg, rr_next;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   cand [NREQ];
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic [NREQ-1:0]  ready_vec;
    logic             start;
    logic             res_valid_c;
    logic             busy_c;
    logic             core_done;

    // cand[k] is the k-th index visited when searching upward from rr.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
            assign cand[gi]  = IDW'((32'(rr_reg) + 32'(gi)) % NREQ);
        end
    endgenerate

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[cand[k]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)         state_next = MUL;
            MUL:     if (core_done)     state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_vec   = '0;
        start       = 1'b0;
        res_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_found && !rst) begin
                    ready_vec[gnt_idx] = 1'b1;
                    start              = 1'b1;
                end
            end
            MUL:  busy_c = 1'b1;
            DONE: begin
                busy_c      = 1'b1;
                res_valid_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign rr_next = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_reg <= '0;
            id_reg <= '0;
        end else begin
            if (start) begin
                id_reg <= gnt_idx;
            end
            if (state_reg == DONE && bus.res_ready) begin
                rr_reg <= rr_next;
            end
        end
    end

    schoolbook_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_arr[gnt_idx]),
        .b     (b_arr[gnt_idx]),
        .done  (core_done),
        .c     (bus.res_c)
    );

    assign bus.req_ready = ready_vec;
    assign bus.res_valid = res_valid_c;
    assign bus.res_id    = id_reg;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_schoolbook_sched.sv
// Randomised scoreboard bench for schoolbook_sched with a queue-based reference model.
module tb_schoolbook_sched;
    import schoolbook_pkg::*;

    localparam int WIDTH = 283;
    localparam int NREQ  = 4;
`ifdef SCHOOLBOOK_SCHED_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [2*WIDTH-1:0] c;
        int                 id;
        int                 t_acc;
        int                 lat;
        bit                 seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    schoolbook_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    schoolbook_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t               sb[$];
    int                 acc_log[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc    = 0;
    int                 ptr    = 0;
    logic [2*WIDTH-1:0] last_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Latency from the rules: constant WIDTH, or highest set bit + 1 (min 1) with early exit.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
        int hb;
        hb = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hb = i + 1;
        if (!EARLY) return WIDTH;
        return (hb < 1) ? 1 : hb;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        logic [319:0] w;
        for (int k = 0; k < 10; k++) w[k*32 +: 32] = $urandom;
        return w[WIDTH-1:0];
    endfunction

    // Monitor: predicts the grant, pushes expectations on accept, pops on result handshake.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0]    exp_rdy;
        int                 g;
        logic [2*WIDTH-1:0] oa, ob;
        exp_t               item;
        if (!rst) begin
            exp_rdy = '0;
            g = -1;
            if (sb.size() == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && bus.req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", bus.busy, sb.size() != 0);
            if (g >= 0) begin
                oa = '0;
                ob = '0;
                oa[WIDTH-1:0] = bus.req_a[g*WIDTH +: WIDTH];
                ob[WIDTH-1:0] = bus.req_b[g*WIDTH +: WIDTH];
                item.c     = oa * ob;
                item.id    = g;
                item.t_acc = cyc;
                item.lat   = exp_lat(ob[WIDTH-1:0]);
                item.seen  = 1'b0;
                sb.push_back(item);
                acc_log.push_back(g);
            end
            if (bus.res_valid) begin
                if (sb.size() == 0 || sb[0].t_acc == cyc) begin
                    chk("res_valid_unexpected", bus.res_valid, 1'b0);
                end else begin
                    if (!sb[0].seen) begin
                        chk("latency", cyc - sb[0].t_acc - 1, sb[0].lat);
                        sb[0].seen = 1'b1;
                    end
                    chk("res_c", bus.res_c, sb[0].c);
                    chk("res_id", bus.res_id, sb[0].id);
                    if (bus.res_ready) begin
                        $display("txn id=%0d lat=%0d c=%0h", sb[0].id, sb[0].lat, bus.res_c);
                        last_c = bus.res_c;
                        ptr = (sb[0].id + 1) % NREQ;
                        void'(sb.pop_front());
                    end
                end
            end else if (sb.size() != 0 && sb[0].t_acc != cyc &&
                         (sb[0].seen || cyc == sb[0].t_acc + 1 + sb[0].lat)) begin
                chk("res_valid_missing", bus.res_valid, 1'b1);
                sb[0].seen = 1'b1;
            end
        end
    end

    task automatic send(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_valid[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready[i]) chk("accept_timeout", bus.req_ready[i], 1'b1);
        @(posedge clk);
        #1 bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        acc_log.delete();
        ptr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #(900_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2*WIDTH-1:0] want;
        logic [2*WIDTH-1:0] tmp;
        logic [WIDTH-1:0]   ra, rb;
        int                 n;
        int                 r_cyc;
        int                 exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_c", bus.res_c, 0);
        chk("rst_res_id", bus.res_id, 0);
        bus.req_valid = '0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request from requester 2.
        send(2, WIDTH'(3), WIDTH'(5));
        drain(400);
        chk("single_c", last_c, 15);

        // Round-robin with all requesters valid continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
            bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(2);
        end
        bus.req_valid = '1;
        n = 0;
        while (acc_log.size() < 5 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 bus.req_valid = '0;
        drain(400);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (k < acc_log.size()) ? acc_log[k] : -1, exp_order[k]);
        end
        chk("rr_last_c", last_c, 2);

        // Back-pressure: hold in DONE while another requester waits.
        bus.res_ready = 1'b0;
        ra = rnd_op();
        rb = rnd_op();
        send(1, ra, rb);
        n = 0;
        while (!bus.res_valid && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.req_a[3*WIDTH +: WIDTH] = WIDTH'(11);
        bus.req_b[3*WIDTH +: WIDTH] = WIDTH'(13);
        bus.req_valid[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        r_cyc = cyc;
        @(negedge clk);
        chk("bp_accept_next_idle", bus.req_ready[3], 1'b1);
        chk("bp_accept_cycle", cyc - r_cyc, 1);
        @(posedge clk);
        #1 bus.req_valid[3] = 1'b0;
        drain(400);
        chk("bp_follow_c", last_c, 143);

        // Maximum operands.
        send(0, '1, '1);
        drain(400);
        tmp = '0;
        tmp[WIDTH+1] = 1'b1;
        want = '0 - tmp + 1;
        chk("max_c", last_c, want);

        // Reset in the middle of a multiplication.
        rb = rnd_op();
        rb[WIDTH-1] = 1'b1;
        send(0, rnd_op(), rb);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        acc_log.delete();
        ptr = 0;
        #1;
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        chk("midrst_res_c", bus.res_c, 0);
        chk("midrst_res_id", bus.res_id, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, WIDTH'(7), WIDTH'(9));
        drain(400);
        chk("post_rst_c", last_c, 63);

        // b=1: one-cycle latency only with early termination.
        send(3, WIDTH'(12345), WIDTH'(1));
        drain(400);
        chk("b1_c", last_c, 12345);

        // Random traffic: valid drops, operand changes and random back-pressure.
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    bus.req_a[i*WIDTH +: WIDTH] = rnd_op();
                    bus.req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 0) ?
                        rnd_op() : WIDTH'($urandom_range(0, 300));
                end
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/schoolbook_sched.md
# schoolbook_sched

Shares one bit-serial schoolbook multiplier core between `NREQ` requesters. Each requester presents an operand pair through a valid/ready handshake. A round-robin arbiter grants one requester, the core runs the multiplication, and the product is returned on a single result port tagged with the requester index. The block sits between the field-arithmetic front ends and the large-integer multiplier, so several clients can time-multiplex one area-cheap core.

## Interface
- `WIDTH`, 283, operand width in bits; product is `2*WIDTH` bits.
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`, requester-index width.

- `clk` in 1: rising-edge clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester accept; at most one bit high.
- `req_a` in `NREQ*WIDTH`: operand a; requester i is slice `[i*WIDTH +: WIDTH]`.
- `req_b` in `NREQ*WIDTH`: operand b, same slicing.
- `res_valid` out 1: product available.
- `res_ready` in 1: consumer accepts product.
- `res_c` out `2*WIDTH`: product a*b.
- `res_id` out `IDW`: index of the requester that produced `res_c`.
- `busy` out 1: high in MUL and DONE.

## Operation
- FSM states: IDLE, MUL, DONE.
- **IDLE**
  - The arbiter picks the first `req_valid` bit at or after pointer `rr`, searching upward with wrap at `NREQ-1`.
  - `req_ready[g]` is high combinationally for the granted index only.
  - On the edge with `req_valid[g] & req_ready[g]`:
    - `a_sh` ← a_g, zero-extended to `2*WIDTH`.
    - `b_sh` ← b_g.
    - `acc` ← 0, `cnt` ← 0, `res_id` ← g.
    - FSM → MUL.
- **MUL**, one step per cycle
  - If `b_sh[0]`: `acc` ← `acc + a_sh`.
  - `a_sh` ← `a_sh << 1`, `b_sh` ← `b_sh >> 1`, `cnt` ← `cnt + 1`.
  - On the step where `cnt == WIDTH-1`: FSM → DONE.
  - Arithmetic is exact. `acc` is `2*WIDTH` bits, no truncation. `cnt` is `$clog2(WIDTH+1)` bits.
  - `req_ready` is all zero.
- **DONE**
  - `res_valid` = 1; `res_c` = `acc`.
  - On `res_valid & res_ready`: `rr` ← `(res_id + 1) mod NREQ`, FSM → IDLE.
  - `res_c` and `res_id` hold stable until accepted.
- Requesters may drop `req_valid` before being granted. Operands are sampled only on the accept edge.
- Reset values: state IDLE, `rr` = 0, `acc` / `res_c` = 0, `res_id` = 0, `res_valid` = 0, `req_ready` = 0 while `rst` is high, `busy` = 0.
- Reset mid-operation: everything clears asynchronously. The in-flight product is discarded and no `res_valid` is emitted for it.

## Timing
- Accept edge E0; MUL steps occur at E1..E`WIDTH`.
- `res_valid` rises in the cycle after E`WIDTH`, i.e. `WIDTH` cycles after acceptance.
- With `res_ready` held high: DONE lasts 1 cycle, then IDLE lasts 1 cycle before the next accept. Peak throughput is one product per `WIDTH+2` cycles.
- Back-pressure (`res_ready` = 0) stalls in DONE indefinitely; no new request is accepted.
- `req_ready` depends combinationally on `req_valid`. `req_valid` must not depend combinationally on `req_ready`.

## Configuration
- Macro: `SCHOOLBOOK_SCHED_EARLY_TERM_EN`.
- **Defined:** MUL also transitions to DONE on any step where `(b_sh >> 1) == 0`, i.e. no set bits remain.
  - Latency becomes `max(1, index of highest set bit of b + 1)` cycles.
  - Examples: b=0 gives 1 cycle; b=1 gives 1 cycle.
- **Undefined:** latency is always exactly `WIDTH` cycles. This is the default constant-time mode, required for cryptographic use.

## Structure
- Package `schoolbook_pkg`:
  - State enum `sched_state_t` (IDLE, MUL, DONE).
  - Default `WIDTH` constant.
  - Counter-width localparam.
- Sub-module `schoolbook_core`:
  - Ports: `start`, `a`, `b`, `done`, `c`.
  - Holds `acc`, `a_sh`, `b_sh`, `cnt` and the step logic.
  - The macro is applied here.
- Top-level logic: arbiter, `rr` pointer, FSM, result port.

## Test plan
- **Single request:** requester 2 presents a=3, b=5. Expect `res_c`=15 and `res_id`=2, with `res_valid` rising exactly 283 cycles after the accept edge.
- **Round-robin:** all four requesters valid continuously from reset, each with a=i+1, b=2. Expect grant order 0,1,2,3,0 and products 2,4,6,8,2.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles in DONE. Expect `res_c`/`res_id` stable, `req_ready`=0, `busy`=1, and acceptance in the IDLE cycle after release.
- **Maximum operands:** a=b=2^283−1. Expect `res_c`=2^566−2^284+1.
- **Reset mid-operation:** assert `rst` at `cnt`=100. Expect all outputs 0 immediately and no stale `res_valid`. A following request a=7, b=9 returns 63.
- **Macro defined:** b=1, a=12345. Expect `res_valid` 1 cycle after accept and `res_c`=12345. Without the macro the same stimulus takes 283 cycles.
